bcd_signmag_accumulator: RTL and testbench

//  Parametrised successor to the four-digit signed up/down counter.

---
 rtl/bcd_signmag_accumulator.sv | 151 +++++++++++++++
 tb/tb_bcd_signmag_accumulator.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bcd_signmag_accumulator.sv
// Sign-magnitude BCD accumulator: digit-serial add/subtract of a BCD step,
// with a start/busy/done handshake, synchronous load and invalid-BCD rejection.
//
//   state | meaning
//   IDLE  | waiting for load or start; Q/sign hold the committed value
//   MAG   | one digit per edge of |Q| +/- step, LSD first
//   NEG   | ten's-complement of the MAG result after a borrow out
module bcd_signmag_accumulator #(
  parameter int DIGITS      = 4,
  parameter int STEP_DIGITS = 1,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [4*STEP_DIGITS-1:0] step,
  input  logic                     load,
  input  logic [4*DIGITS-1:0]      load_val,
  input  logic                     load_sign,
  output logic [4*DIGITS-1:0]      Q,
  output logic                     sign,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     err
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, MAG, NEG} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   work, stp, result, commit_val;
  logic [CW-1:0]  cnt;
  logic           carry, op_sub, last, sub, c_out, step_ok;
  logic [3:0]     a, b, digit;
  logic [4:0]     sum, dif;

  function automatic logic bcd_valid(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  assign busy    = (state_q != IDLE);
  assign step_ok = bcd_valid(W'(step));

  always_comb begin
    state_d = state_q;
    last    = (cnt == '0);
    // NEG reuses the subtractor as 0 - work to form the ten's complement
    a       = (state_q == NEG) ? 4'd0 : work[3:0];
    b       = (state_q == NEG) ? work[3:0] : stp[3:0];
    sub     = (state_q == NEG) || op_sub;
    sum     = {1'b0, a} + {1'b0, b} + {4'd0, carry};
    dif     = {1'b0, a} - {1'b0, b} - {4'd0, carry};
    if (sub) begin
      c_out = dif[4];
      digit = dif[4] ? dif[3:0] + 4'd10 : dif[3:0];
    end else begin
      c_out = (sum > 5'd9);
      digit = c_out ? sum[3:0] + 4'd6 : sum[3:0];
    end
    result     = {digit, work[W-1:4]};
    commit_val = (!op_sub && c_out && SATURATE) ? NINES : result;
    case (state_q)
      IDLE:    if (!load && start && step_ok) state_d = MAG;
      MAG:     if (last) state_d = (op_sub && c_out) ? NEG : IDLE;
      NEG:     if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q        <= '0;
      sign     <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
      work     <= '0;
      stp      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      op_sub   <= 1'b0;
    end else begin
      done     <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            done <= 1'b1;
            if (bcd_valid(load_val)) begin
              Q    <= load_val;
              sign <= (load_val == '0) ? 1'b1 : load_sign;
            end else begin
              err <= 1'b1;
            end
          end else if (start) begin
            if (!step_ok) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              work   <= Q;
              stp    <= W'(step);
              op_sub <= (mode == sign);
              cnt    <= CW'(DIGITS - 1);
              carry  <= 1'b0;
            end
          end
        end
        MAG: begin
          work  <= result;
          stp   <= stp >> 4;
          carry <= c_out;
          cnt   <= cnt - 1'b1;
          if (last) begin
            if (op_sub && c_out) begin
              cnt   <= CW'(DIGITS - 1);
              carry <= 1'b0;
            end else begin
              done     <= 1'b1;
              overflow <= !op_sub && c_out;
              Q        <= commit_val;
              sign     <= (commit_val == '0) ? 1'b1 : sign;
            end
          end
        end
        NEG: begin
          work  <= result;
          carry <= c_out;
          cnt   <= cnt - 1'b1;
          if (last) begin
            done <= 1'b1;
            Q    <= result;
            sign <= (result == '0) ? 1'b1 : ~sign;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_signmag_accumulator.sv
// Directed bench: wrap and saturate instances share stimulus; expected values
// are hand-computed four-digit BCD results.
module tb_bcd_signmag_accumulator;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic        load = 1'b0, load_sign = 1'b1;
  logic [3:0]  step = 4'd0;
  logic [15:0] load_val = 16'h0;
  logic [15:0] q0, q1;
  logic        sign0, sign1, busy0, busy1, done0, done1, ovf0, ovf1, err0, err1;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  bcd_signmag_accumulator #(.DIGITS(4), .STEP_DIGITS(1), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .step(step), .load(load),
    .load_val(load_val), .load_sign(load_sign), .Q(q0), .sign(sign0), .busy(busy0),
    .done(done0), .overflow(ovf0), .err(err0));

  bcd_signmag_accumulator #(.DIGITS(4), .STEP_DIGITS(1), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .step(step), .load(load),
    .load_val(load_val), .load_sign(load_sign), .Q(q1), .sign(sign1), .busy(busy1),
    .done(done1), .overflow(ovf1), .err(err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic [3:0] s, input int lat,
                        input logic [15:0] eq0, input logic [15:0] eq1,
                        input logic es, input logic eo, input logic ee);
    int n = 0;
    @(negedge clk); start = 1'b1; mode = m; step = s;
    @(negedge clk); start = 1'b0;
    while (!done0 && n < 40) begin @(negedge clk); n++; end
    check({tag, " latency"}, n, lat);
    check({tag, " done_sat"}, done1, 1'b1);
    check({tag, " q_wrap"}, q0, eq0);
    check({tag, " q_sat"}, q1, eq1);
    check({tag, " sign_wrap"}, sign0, es);
    check({tag, " sign_sat"}, sign1, es);
    check({tag, " ovf_wrap"}, ovf0, eo);
    check({tag, " ovf_sat"}, ovf1, eo);
    check({tag, " err"}, err0, ee);
    check({tag, " busy"}, busy0, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [15:0] v, input logic s,
                         input logic [15:0] eq, input logic es, input logic ee);
    @(negedge clk); load = 1'b1; load_val = v; load_sign = s;
    @(negedge clk); load = 1'b0;
    check({tag, " done"}, done0, 1'b1);
    check({tag, " err"}, err0, ee);
    check({tag, " q_wrap"}, q0, eq);
    check({tag, " q_sat"}, q1, eq);
    check({tag, " sign"}, sign0, es);
    check({tag, " busy"}, busy0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst q", q0, 16'h0000);
    check("rst sign", sign0, 1'b1);
    check("rst busy", busy0, 1'b0);
    check("rst done", done0, 1'b0);
    reset = 1'b1;

    do_load("ld9", 16'h0009, 1'b1, 16'h0009, 1'b1, 1'b0);
    run_op("9+1", 1'b0, 4'd1, 4, 16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0);

    do_load("ld3", 16'h0003, 1'b1, 16'h0003, 1'b1, 1'b0);
    run_op("3-7", 1'b1, 4'd7, 8, 16'h0004, 16'h0004, 1'b0, 1'b0, 1'b0);

    do_load("ldm4", 16'h0004, 1'b0, 16'h0004, 1'b0, 1'b0);
    run_op("-4+4", 1'b0, 4'd4, 4, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("0-5", 1'b1, 4'd5, 8, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0);
    run_op("-5-9", 1'b1, 4'd9, 4, 16'h0014, 16'h0014, 1'b0, 1'b0, 1'b0);

    do_load("ld9998", 16'h9998, 1'b1, 16'h9998, 1'b1, 1'b0);
    run_op("9998+5", 1'b0, 4'd5, 4, 16'h0003, 16'h9999, 1'b1, 1'b1, 1'b0);

    do_load("ld42", 16'h0042, 1'b1, 16'h0042, 1'b1, 1'b0);
    run_op("stepA", 1'b0, 4'hA, 0, 16'h0042, 16'h0042, 1'b1, 1'b0, 1'b1);
    do_load("ld12F4", 16'h12F4, 1'b0, 16'h0042, 1'b1, 1'b1);
    do_load("ldm0", 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset while NEG is running
    do_load("ld3b", 16'h0003, 1'b1, 16'h0003, 1'b1, 1'b0);
    @(negedge clk); start = 1'b1; mode = 1'b1; step = 4'd7;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("midneg busy", busy0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst q", q0, 16'h0000);
    check("arst sign", sign0, 1'b1);
    check("arst busy", busy0, 1'b0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post rst q", q0, 16'h0000);

    // A start pulse while busy must not be queued
    do_load("ld10", 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0);
    @(negedge clk); start = 1'b1; mode = 1'b0; step = 4'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; step = 4'd5;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy ign done", done0, 1'b1);
    check("busy ign q", q0, 16'h0012);
    repeat (6) @(negedge clk);
    check("busy ign q2", q0, 16'h0012);
    check("busy ign idle", busy0, 1'b0);

    // load beats start in the same cycle
    @(negedge clk); load = 1'b1; load_val = 16'h0777; load_sign = 1'b1;
    start = 1'b1; mode = 1'b0; step = 4'd1;
    @(negedge clk); load = 1'b0; start = 1'b0;
    check("ld+st done", done0, 1'b1);
    check("ld+st busy", busy0, 1'b0);
    check("ld+st q", q0, 16'h0777);
    repeat (6) @(negedge clk);
    check("ld+st q2", q0, 16'h0777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
